sorted_output_packer: RTL and testbench

- Sits at the root of the merger tree and produces the write-side stream.
- Takes sorted records from the tree root, IN_LANES per beat, and packs them into OUT_LANES-wide (512-bit) AXI-Stream-style beats for the write DMA.
- Flushes a partial beat when a sorted run ends (padding with PAD_VALUE so the beat stays ascending).
- Flags any ordering violation it sees in the stream.

---
 rtl/sorted_output_packer_pkg.sv | 20 ++
 rtl/sorted_output_packer_order_checker.sv | 52 +++++
 rtl/sorted_output_packer.sv | 103 ++++++++++
 tb/tb_sorted_output_packer.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sorted_output_packer_pkg.sv
// Shared constants and record-slicing helper for the sort write path.
// Imported by the output packer, its order checker and presort/distribution logic.
package sorted_output_packer_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_IN_LANES   = 8;
    localparam int DEF_OUT_LANES  = 16;
    localparam int DEF_BUS_WIDTH  = DEF_OUT_LANES * DEF_DATA_WIDTH;

    localparam logic [DEF_DATA_WIDTH-1:0] DEF_PAD_VALUE = '1;

    // Narrower buses are zero-extended to DEF_BUS_WIDTH by the caller.
    function automatic logic [DEF_DATA_WIDTH-1:0] lane_sel(
        input logic [DEF_BUS_WIDTH-1:0] bus,
        input int                       idx
    );
        return bus[idx*DEF_DATA_WIDTH +: DEF_DATA_WIDTH];
    endfunction

endpackage

// File: rtl/sorted_output_packer_order_checker.sv
// Watches accepted beats of a sorted stream and raises a sticky flag on any descent,
// both inside a beat and from the last record of the previous beat of the same run.
module sorted_output_packer_order_checker
    import sorted_output_packer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IN_LANES   = DEF_IN_LANES
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [IN_LANES*DATA_WIDTH-1:0] in_data,
    input  logic                         accept,
    input  logic                         in_last,
    output logic                         order_err
);

    logic [DATA_WIDTH-1:0] lanes [IN_LANES];
    logic [DATA_WIDTH-1:0] prev_max;
    logic                  prev_valid;
    logic                  violation;

    always_comb begin
        for (int k = 0; k < IN_LANES; k++) begin
            lanes[k] = DATA_WIDTH'(lane_sel(DEF_BUS_WIDTH'(in_data), k));
        end
    end

    always_comb begin
        violation = prev_valid && (lanes[0] < prev_max);
        for (int k = 0; k < IN_LANES - 1; k++) begin
            if (lanes[k+1] < lanes[k]) begin
                violation = 1'b1;
            end
        end
    end

    // prev_max is forgotten at a run boundary so a new run may start low.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            order_err  <= 1'b0;
            prev_valid <= 1'b0;
            prev_max   <= '0;
        end else if (accept) begin
            if (violation) begin
                order_err <= 1'b1;
            end
            prev_max   <= lanes[IN_LANES-1];
            prev_valid <= !in_last;
        end
    end

endmodule

// File: rtl/sorted_output_packer.sv
// Packs IN_LANES-wide sorted beats from the merger root into OUT_LANES-wide write beats,
// flushing a PAD_VALUE-padded partial beat whenever a sorted run ends.
module sorted_output_packer
    import sorted_output_packer_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    IN_LANES   = DEF_IN_LANES,
    parameter int                    OUT_LANES  = DEF_OUT_LANES,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '1
) (
    input  logic                            aclk,
    input  logic                            aresetn,
    input  logic [IN_LANES*DATA_WIDTH-1:0]  in_data,
    input  logic                            in_valid,
    input  logic                            in_last,
    output logic                            in_ready,
    output logic [OUT_LANES*DATA_WIDTH-1:0] out_data,
    output logic [OUT_LANES-1:0]            out_keep,
    output logic                            out_valid,
    output logic                            out_last,
    input  logic                            out_ready,
    output logic                            order_err
);

    localparam int SLOTS  = OUT_LANES / IN_LANES;
    localparam int SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int IN_W   = IN_LANES * DATA_WIDTH;
    localparam int OUT_W  = OUT_LANES * DATA_WIDTH;

    logic [SLOT_W-1:0]    slot;
    logic [OUT_W-1:0]     acc;
    logic [OUT_W-1:0]     beat_data;
    logic [OUT_LANES-1:0] beat_keep;
    logic                 accept;
    logic                 slot_full;
    logic                 complete;

    // Stalling every input while a beat is held keeps in_ready independent of in_valid.
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign slot_full = (slot == SLOT_W'(SLOTS - 1));
    assign complete  = accept && (slot_full || in_last);

    always_comb begin
        beat_data = '0;
        beat_keep = '0;
        for (int l = 0; l < OUT_LANES; l++) begin
            if ((l / IN_LANES) < int'(slot)) begin
                beat_data[l*DATA_WIDTH +: DATA_WIDTH] =
                    DATA_WIDTH'(lane_sel(DEF_BUS_WIDTH'(acc), l));
                beat_keep[l] = 1'b1;
            end else if ((l / IN_LANES) == int'(slot)) begin
                beat_data[l*DATA_WIDTH +: DATA_WIDTH] =
                    in_data[(l % IN_LANES)*DATA_WIDTH +: DATA_WIDTH];
                beat_keep[l] = 1'b1;
            end else begin
                beat_data[l*DATA_WIDTH +: DATA_WIDTH] = PAD_VALUE;
            end
        end
    end

    // Accumulator contents are meaningless after reset, so it carries no reset.
    always_ff @(posedge aclk) begin
        if (accept) begin
            acc[int'(slot)*IN_W +: IN_W] <= in_data;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            slot      <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
        end else begin
            if (accept) begin
                slot <= complete ? '0 : slot + SLOT_W'(1);
            end
            if (complete) begin
                out_data  <= beat_data;
                out_keep  <= beat_keep;
                out_last  <= in_last;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    sorted_output_packer_order_checker #(
        .DATA_WIDTH (DATA_WIDTH),
        .IN_LANES   (IN_LANES)
    ) u_order_checker (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_data   (in_data),
        .accept    (accept),
        .in_last   (in_last),
        .order_err (order_err)
    );

endmodule

// File: tb/tb_sorted_output_packer.sv
// Randomized and directed bench for sorted_output_packer, checked against a record-level
// queue model of packing, padding and run ordering; a second instance covers IN_LANES=16.
module tb_sorted_output_packer;

    localparam int DW = 32;
    localparam int IL = 8;
    localparam int OL = 16;
    localparam int IW = IL * DW;
    localparam int OW = OL * DW;

    typedef struct {
        logic [OW-1:0] data;
        logic [OL-1:0] keep;
        logic          last;
    } beat_t;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [OW-1:0] out_data;
    logic [OL-1:0] out_keep;
    logic          out_valid;
    logic          out_last;
    logic          out_ready = 1'b1;
    logic          order_err;

    logic [OW-1:0] w_in_data = '0;
    logic          w_in_valid = 1'b0;
    logic          w_in_last = 1'b0;
    logic          w_in_ready;
    logic [OW-1:0] w_out_data;
    logic [OL-1:0] w_out_keep;
    logic          w_out_valid;
    logic          w_out_last;
    logic          w_order_err;

    int            n_checks = 0;
    int            n_fails = 0;
    int            ready_mode = 0;
    logic [31:0]   next_val = 0;

    beat_t         exp_q[$];
    logic [DW-1:0] pend[$];
    logic          exp_err = 1'b0;
    logic          run_prev_valid = 1'b0;
    logic [DW-1:0] run_prev = '0;

    logic          prev_stall = 1'b0;
    logic [OW-1:0] prev_data;
    logic [OL-1:0] prev_keep;
    logic          prev_last;

    sorted_output_packer dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .order_err (order_err)
    );

    sorted_output_packer #(.IN_LANES(16)) dut_wide (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_data   (w_in_data),
        .in_valid  (w_in_valid),
        .in_last   (w_in_last),
        .in_ready  (w_in_ready),
        .out_data  (w_out_data),
        .out_keep  (w_out_keep),
        .out_valid (w_out_valid),
        .out_last  (w_out_last),
        .out_ready (1'b1),
        .order_err (w_order_err)
    );

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string tag, input logic [OW-1:0] observed,
                               input logic [OW-1:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        pend.delete();
        exp_err        = 1'b0;
        run_prev_valid = 1'b0;
    endtask

    // Records are treated as one flat stream per run; any descent is an ordering error.
    task automatic model_accept(input logic [IW-1:0] d, input logic last);
        beat_t b;
        int    n;
        for (int k = 0; k < IL; k++) begin
            if (run_prev_valid && d[k*DW +: DW] < run_prev) exp_err = 1'b1;
            run_prev       = d[k*DW +: DW];
            run_prev_valid = 1'b1;
            pend.push_back(d[k*DW +: DW]);
        end
        if (pend.size() == OL || last) begin
            n = pend.size();
            for (int l = 0; l < OL; l++) begin
                b.data[l*DW +: DW] = (l < n) ? pend[l] : 32'hFFFF_FFFF;
                b.keep[l]          = (l < n);
            end
            b.last = last;
            exp_q.push_back(b);
            pend.delete();
            if (last) run_prev_valid = 1'b0;
        end
    endtask

    always @(negedge aclk) begin
        beat_t b;
        #4;
        if (!aresetn) begin
            checkOutput("rst_out_valid", out_valid, 0);
            checkOutput("rst_order_err", order_err, 0);
            checkOutput("rst_in_ready", in_ready, 1);
            prev_stall = 1'b0;
        end else begin
            checkOutput("out_valid", out_valid, exp_q.size() != 0);
            checkOutput("in_ready", in_ready, (exp_q.size() == 0) || out_ready);
            checkOutput("order_err", order_err, exp_err);
            if (prev_stall) begin
                checkOutput("hold_data", out_data, prev_data);
                checkOutput("hold_keep", out_keep, prev_keep);
                checkOutput("hold_last", out_last, prev_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_keep  = out_keep;
            prev_last  = out_last;
            if (out_valid && out_ready && exp_q.size() != 0) begin
                b = exp_q.pop_front();
                checkOutput("beat_data", out_data, b.data);
                checkOutput("beat_keep", out_keep, b.keep);
                checkOutput("beat_last", out_last, b.last);
            end
            if (in_valid && in_ready) model_accept(in_data, in_last);
        end
    end

    initial begin
        forever begin
            @(negedge aclk);
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    function automatic logic [IW-1:0] ramp(input logic [31:0] start);
        logic [IW-1:0] r;
        for (int k = 0; k < IL; k++) r[k*DW +: DW] = start + 32'(k);
        return r;
    endfunction

    function automatic logic [IW-1:0] random_beat();
        logic [IW-1:0] r;
        if ($urandom_range(0, 19) == 0) next_val = next_val - 32'($urandom_range(0, 40));
        for (int k = 0; k < IL; k++) begin
            next_val = next_val + 32'($urandom_range(0, 3));
            r[k*DW +: DW] = next_val;
        end
        if ($urandom_range(0, 29) == 0 && next_val > 10) r[3*DW +: DW] = next_val - 5;
        return r;
    endfunction

    task automatic applyStimulus(input logic [IW-1:0] d, input logic last);
        int waited = 0;
        @(negedge aclk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        #4;
        while (!in_ready && waited < 300) begin
            @(negedge aclk);
            #4;
            waited++;
        end
        if (!in_ready) checkOutput("accept_timeout", in_ready, 1);
        @(posedge aclk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge aclk);
            in_valid = 1'b0;
            in_data  = 'x;
            in_last  = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn  = 1'b0;
        in_valid = 1'b0;
        model_reset();
        #4;
        checkOutput("rst_wide_valid", w_out_valid, 0);
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [OW-1:0] wide_beat;
        logic          wide_last;

        model_reset();
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;

        // Reset mid-beat discards the partial beat, then a clean full beat follows.
        applyStimulus(ramp(1000), 1'b0);
        do_reset();
        checkOutput("after_rst_valid", out_valid, 0);
        applyStimulus(ramp(0), 1'b0);
        applyStimulus(ramp(8), 1'b0);
        idle(3);

        // Partial flush with padding.
        do_reset();
        applyStimulus(ramp(1), 1'b1);
        idle(3);

        // Back-pressure then a completing input meeting the handshake edge.
        do_reset();
        ready_mode = 1;
        applyStimulus(ramp(10), 1'b0);
        applyStimulus(ramp(18), 1'b0);
        fork
            applyStimulus(ramp(26), 1'b1);
            begin
                repeat (5) begin
                    @(negedge aclk);
                    #4;
                    checkOutput("stall_in_ready", in_ready, 0);
                end
                ready_mode = 0;
            end
        join
        idle(3);

        // Streaming 64 ascending beats.
        do_reset();
        for (int i = 0; i < 64; i++) applyStimulus(ramp(32'(i * IL)), 1'b0);
        idle(3);

        // Run boundary does not compare, a cross-beat descent does.
        do_reset();
        applyStimulus(ramp(93), 1'b1);
        applyStimulus(ramp(5), 1'b1);
        idle(2);
        #4;
        checkOutput("run_boundary_err", order_err, 0);
        applyStimulus(ramp(93), 1'b0);
        applyStimulus(ramp(99), 1'b0);
        idle(1);
        #4;
        checkOutput("cross_beat_err", order_err, 1);
        idle(3);
        #4;
        checkOutput("err_sticky", order_err, 1);

        // Randomized traffic with random back-pressure, gaps, run ends and resets.
        do_reset();
        ready_mode = 2;
        next_val = 0;
        for (int i = 0; i < 300; i++) begin
            if (i % 100 == 99) do_reset();
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            applyStimulus(random_beat(), 1'($urandom_range(0, 5) == 0));
        end
        ready_mode = 0;
        idle(6);
        checkOutput("drained", 32'(exp_q.size()), 0);

        // Single-slot instance: every beat passes straight through with latency one.
        next_val = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge aclk);
            for (int k = 0; k < OL; k++) begin
                next_val = next_val + 32'($urandom_range(0, 5));
                wide_beat[k*DW +: DW] = next_val;
            end
            wide_last  = 1'($urandom_range(0, 1));
            w_in_data  = wide_beat;
            w_in_last  = wide_last;
            w_in_valid = 1'b1;
            #4;
            checkOutput("wide_in_ready", w_in_ready, 1);
            @(negedge aclk);
            w_in_valid = 1'b0;
            #4;
            checkOutput("wide_valid", w_out_valid, 1);
            checkOutput("wide_data", w_out_data, wide_beat);
            checkOutput("wide_keep", w_out_keep, 16'hFFFF);
            checkOutput("wide_last", w_out_last, wide_last);
        end
        @(negedge aclk);
        #4;
        checkOutput("wide_drop", w_out_valid, 0);
        checkOutput("wide_err", w_order_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
        $finish;
    end

endmodule
